// File: rtl/pio_ctrl_pkg.sv
// Shared types and constants for the PIO write-port controller.
package pio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2,
        ST_GAP   = 2'd3
    } pio_state_t;

    localparam int unsigned CNT_LSB   = 0;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned LED_LSB   = 2;
    localparam int unsigned LED_W     = 8;
    localparam int unsigned GPIO_LSB  = 10;
    localparam int unsigned GPIO_W    = 22;

    // LED field 8'h2A, counter_set 0, GPIO 0: matches the PIO's own reset value.
    localparam logic [31:0] PIO_RESET_WORD = 32'h0000_00A8;

    function automatic logic [31:0] pio_merge(input logic [31:0] shadow,
                                              input logic [31:0] wdata,
                                              input logic [31:0] wmask);
        return (shadow & ~wmask) | (wdata & wmask);
    endfunction

endpackage

// File: rtl/pio_write_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: req[0] = CPU, req[1] = aux.
// On a tie the requester not served last wins; last_grant resets to aux.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_aux;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_aux ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_aux <= 1'b1;
        end else if (advance && (|grant)) begin
            last_aux <= grant[1];
        end
    end

endmodule

// File: rtl/pio_write_ctrl.sv
// Write-port controller for the PIO register: arbitrates CPU/aux stores, merges
// masked writes into a shadow copy and issues one-cycle pio_en. Aux path: PIO_CTRL_AUX_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting; requests sampled and one granted each edge
// ST_WRITE | pio_en high, pio_data holds merged word; shadow updates at exit
// ST_ACK   | one-cycle ack to the granted requester
// ST_GAP   | GAP_CYCLES forced idle cycles; requests stay pending
module pio_write_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_wmask,
    output logic        cpu_ack,
    input  logic        aux_req,
    input  logic [31:0] aux_wdata,
    input  logic [31:0] aux_wmask,
    output logic        aux_ack,
    output logic        pio_en,
    output logic [31:0] pio_data,
    output logic [31:0] pio_shadow,
    output logic        busy
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    pio_state_t  state;
    logic [3:0]  gap_cnt;
    logic [1:0]  grant;
    logic [31:0] merged;

`ifdef PIO_CTRL_AUX_EN
    logic advance;
    logic grant_aux;
    logic aux_ack_q;

    assign advance = (state == ST_IDLE) && (cpu_req || aux_req);
    assign aux_ack = aux_ack_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({aux_req, cpu_req}),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        merged = pio_merge(pio_shadow, cpu_wdata, cpu_wmask);
        if (grant[1]) begin
            merged = pio_merge(pio_shadow, aux_wdata, aux_wmask);
        end
    end
`else
    // Without the aux requester the CPU is the only source; aux inputs are dead.
    logic unused_aux;

    assign grant      = {1'b0, cpu_req};
    assign merged     = pio_merge(pio_shadow, cpu_wdata, cpu_wmask);
    assign aux_ack    = 1'b0;
    assign unused_aux = ^{aux_req, aux_wdata, aux_wmask, grant[1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gap_cnt    <= 4'd0;
            pio_en     <= 1'b0;
            cpu_ack    <= 1'b0;
            busy       <= 1'b0;
            pio_data   <= PIO_RESET_WORD;
            pio_shadow <= PIO_RESET_WORD;
`ifdef PIO_CTRL_AUX_EN
            grant_aux  <= 1'b0;
            aux_ack_q  <= 1'b0;
`endif
        end else begin
            pio_en  <= 1'b0;
            cpu_ack <= 1'b0;
`ifdef PIO_CTRL_AUX_EN
            aux_ack_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        pio_data <= merged;
                        pio_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_WRITE;
`ifdef PIO_CTRL_AUX_EN
                        grant_aux <= grant[1];
`endif
                    end
                end
                ST_WRITE: begin
                    pio_shadow <= pio_data;
                    state      <= ST_ACK;
`ifdef PIO_CTRL_AUX_EN
                    cpu_ack   <= ~grant_aux;
                    aux_ack_q <= grant_aux;
`else
                    cpu_ack   <= 1'b1;
`endif
                end
                ST_ACK: begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_write_ctrl.sv
// Bench for pio_write_ctrl: two instances (GAP_CYCLES 0 and 4) against a
// transaction-level model; directed cases followed by random requesters.
module tb_pio_write_ctrl;

`ifdef PIO_CTRL_AUX_EN
    localparam bit AUX_ON = 1'b1;
`else
    localparam bit AUX_ON = 1'b0;
`endif
    localparam logic [31:0] RST_WORD = 32'h0000_00A8;
    localparam int GAP_OF[2] = '{0, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, aux_req = 1'b0;
    logic [31:0] cpu_wdata = '0, cpu_wmask = '0, aux_wdata = '0, aux_wmask = '0;

    logic        cpu_ack [2];
    logic        aux_ack [2];
    logic        pio_en  [2];
    logic        busy    [2];
    logic [31:0] pio_data   [2];
    logic [31:0] pio_shadow [2];

    always #5 clk = ~clk;

    pio_write_ctrl #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack[0]),
        .aux_req(aux_req), .aux_wdata(aux_wdata), .aux_wmask(aux_wmask), .aux_ack(aux_ack[0]),
        .pio_en(pio_en[0]), .pio_data(pio_data[0]), .pio_shadow(pio_shadow[0]), .busy(busy[0])
    );

    pio_write_ctrl #(.GAP_CYCLES(4)) dut_gap (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack[1]),
        .aux_req(aux_req), .aux_wdata(aux_wdata), .aux_wmask(aux_wmask), .aux_ack(aux_ack[1]),
        .pio_en(pio_en[1]), .pio_data(pio_data[1]), .pio_shadow(pio_shadow[1]), .busy(busy[1])
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Transaction model: each grant schedules en/ack/shadow/free-edge by arithmetic.
    int          e_cur = 0;
    int          free_edge [2];
    int          en_at [2];
    int          ack_at [2];
    bit          who_aux [2];
    bit          last_aux [2];
    logic [31:0] m_shadow [2];
    logic [31:0] m_data [2];
    bit          g_cpu, g_aux;

    task automatic model_edge(input int i, input int e);
        bit c, a, win_aux;
        if (i == 0) begin g_cpu = 0; g_aux = 0; end
        if (rst) begin
            m_shadow[i] = RST_WORD;
            m_data[i]   = RST_WORD;
            last_aux[i] = 1'b1;
            free_edge[i] = e + 1;
            en_at[i]  = -10;
            ack_at[i] = -10;
        end else begin
            if (e == en_at[i] + 1) m_shadow[i] = m_data[i];
            c = cpu_req;
            a = aux_req && AUX_ON;
            if (e >= free_edge[i] && (c || a)) begin
                win_aux = (c && a) ? !last_aux[i] : a;
                last_aux[i] = win_aux;
                if (win_aux) m_data[i] = (m_shadow[i] & ~aux_wmask) | (aux_wdata & aux_wmask);
                else         m_data[i] = (m_shadow[i] & ~cpu_wmask) | (cpu_wdata & cpu_wmask);
                who_aux[i]   = win_aux;
                en_at[i]     = e;
                ack_at[i]    = e + 1;
                free_edge[i] = e + 3 + GAP_OF[i];
                if (i == 0) begin g_cpu = !win_aux; g_aux = win_aux; end
            end
        end
    endtask

    bit log_on = 0;
    int en_log [2][$];
    bit ack_log [$];

    task automatic tick();
        for (int i = 0; i < 2; i++) model_edge(i, e_cur + 1);
        @(posedge clk);
        e_cur++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pio_en[%0d]", i), 32'(pio_en[i]), 32'(en_at[i] == e_cur));
            chk($sformatf("pio_data[%0d]", i), pio_data[i], m_data[i]);
            chk($sformatf("pio_shadow[%0d]", i), pio_shadow[i], m_shadow[i]);
            chk($sformatf("cpu_ack[%0d]", i), 32'(cpu_ack[i]), 32'(ack_at[i] == e_cur && !who_aux[i]));
            chk($sformatf("aux_ack[%0d]", i), 32'(aux_ack[i]), 32'(ack_at[i] == e_cur && who_aux[i]));
            chk($sformatf("busy[%0d]", i), 32'(busy[i]),
                32'(e_cur >= en_at[i] && e_cur < free_edge[i] - 1));
            if (log_on && pio_en[i]) en_log[i].push_back(e_cur);
        end
        if (log_on && cpu_ack[0]) ack_log.push_back(1'b0);
        if (log_on && aux_ack[0]) ack_log.push_back(1'b1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [31:0] rand_mask();
        case ($urandom % 4)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    bit cpu_wait = 0, aux_wait = 0;
    bit exp_order [4];

    initial begin
        @(negedge clk);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(3);
        chk("reset_shadow", pio_shadow[0], 32'h0000_00A8);
        chk("reset_en", 32'(pio_en[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_acks", {30'd0, aux_ack[0], cpu_ack[0]}, 32'd0);

        // CPU write of the LED field
        cpu_req = 1'b1; cpu_wdata = 32'h0000_03FC; cpu_wmask = 32'h0000_03FC;
        tick();
        chk("cpu_pio_data", pio_data[0], 32'h0000_03FC);
        cpu_req = 1'b0; cpu_wdata = $urandom; cpu_wmask = $urandom;
        ticks(2);
        chk("cpu_shadow", pio_shadow[0], 32'h0000_03FC);
        ticks(6);

        // aux counter_set update keeps the LED field
        aux_req = 1'b1; aux_wdata = 32'h0000_0001; aux_wmask = 32'h0000_0003;
        tick();
        aux_req = 1'b0;
        chk("aux_pio_data", pio_data[0], AUX_ON ? 32'h0000_03FD : 32'h0000_03FC);
        ticks(8);

        // both requesters held: alternation and pulse spacing
        cpu_req = 1'b1; aux_req = 1'b1;
        cpu_wdata = $urandom; cpu_wmask = $urandom; aux_wdata = $urandom; aux_wmask = $urandom;
        log_on = 1;
        ticks(30);
        log_on = 0;
        cpu_req = 1'b0; aux_req = 1'b0;
        exp_order = AUX_ON ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++)
            chk($sformatf("grant_order%0d", k), (k < ack_log.size()) ? 32'(ack_log[k]) : 32'hDEAD, 32'(exp_order[k]));
        chk("en_count_gap0", en_log[0].size(), 32'd10);
        for (int k = 1; k < en_log[0].size(); k++)
            chk("en_spacing_gap0", en_log[0][k] - en_log[0][k-1], 32'd3);
        chk("en_count_gap4", 32'(en_log[1].size() >= 3), 32'd1);
        for (int k = 1; k < en_log[1].size(); k++)
            chk("en_spacing_gap4", en_log[1][k] - en_log[1][k-1], 32'd7);
        ticks(10);

        // reset during WRITE abandons the write; held request is regranted
        cpu_req = 1'b1; cpu_wdata = 32'h1234_5678; cpu_wmask = 32'hFFFF_0000;
        tick();
        chk("pre_rst_en", 32'(pio_en[0]), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_en", 32'(pio_en[0]), 32'd0);
        chk("rst_shadow", pio_shadow[0], 32'h0000_00A8);
        rst = 1'b0;
        tick();
        chk("rst_cpu_ack", 32'(cpu_ack[0]), 32'd0);
        chk("regrant_en", 32'(pio_en[0]), 32'd1);
        cpu_req = 1'b0;
        ticks(10);

        // random requesters, occasional reset
        for (int n = 0; n < 1500; n++) begin
            if (g_cpu) cpu_wait = 0;
            if (g_aux) aux_wait = 0;
            if (!cpu_wait) begin
                cpu_req = ($urandom % 3) != 0;
                cpu_wdata = $urandom;
                cpu_wmask = rand_mask();
                cpu_wait = cpu_req;
            end
            if (!aux_wait) begin
                aux_req = ($urandom % 3) != 0;
                aux_wdata = $urandom;
                aux_wmask = rand_mask();
                aux_wait = aux_req && AUX_ON;
            end
            rst = ($urandom % 150) == 0;
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
